uart_rx_framer: RTL

UART_RX_FRAMER -- requirements
Module: uart_rx_framer

---
 rtl/uart_rx_framer.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_framer.sv
// UART receive framer: start/data/[parity]/stop deframing at OVERSAMPLE x baud, with glitch reject and break handling.
// Latency: 2-cycle input synchronizer; data_out/flags/valid_out update one clk_in after the mid-stop-bit sample.
// Backpressure: none, valid_out is a one-cycle pulse and the word holds until the next frame overwrites it.
// Optional even parity bit enabled by defining UART_RX_FRAMER_PARITY_EN.
module uart_rx_framer #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 sample_tick_in,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    output logic                 frame_err_out,
    output logic                 parity_err_out,
    output logic                 busy_out
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

`ifdef UART_RX_FRAMER_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;
`endif

    logic                 rx_meta;
    logic                 rx_s;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    // Set once the line has been seen high; a break clears it so a held-low
    // line cannot immediately retrigger a new frame.
    logic                 armed_q, armed_d;
    logic                 stop_q, stop_d;
    logic                 done_q, done_d;
`ifdef UART_RX_FRAMER_PARITY_EN
    logic                 par_q, par_d;
`endif

    // Two-flop synchronizer; flops reset to the idle-high line level.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            armed_q <= 1'b0;
            stop_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_RX_FRAMER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            armed_q <= armed_d;
            stop_q  <= stop_d;
            done_q  <= done_d;
`ifdef UART_RX_FRAMER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state logic; everything advances only on sample ticks.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        armed_d = armed_q;
        stop_d  = stop_q;
        done_d  = 1'b0;
`ifdef UART_RX_FRAMER_PARITY_EN
        par_d   = par_q;
`endif
        if (sample_tick_in) begin
            if (rx_s) begin
                armed_d = 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (!rx_s && armed_q) begin
                        state_d = START;
                        cnt_d   = '0;
                    end
                end
                START: begin
                    if (cnt_q == CNT_HALF) begin
                        // Mid start bit: still low means a real frame, else a glitch.
                        cnt_d   = '0;
                        bit_d   = '0;
                        state_d = rx_s ? IDLE : DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_d   = '0;
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bit_q == BIT_LAST) begin
                            bit_d   = '0;
`ifdef UART_RX_FRAMER_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef UART_RX_FRAMER_PARITY_EN
                PARITY: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_d   = '0;
                        par_d   = rx_s;
                        state_d = STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (cnt_q == CNT_FULL) begin
                        // Return to IDLE mid stop bit so the next start edge is caught.
                        cnt_d   = '0;
                        stop_d  = rx_s;
                        done_d  = 1'b1;
                        state_d = IDLE;
                        if (!rx_s) begin
                            armed_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            endcase
        end
    end

    // Publish the completed word and its flags one cycle after the stop sample.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            data_out      <= '0;
            valid_out     <= 1'b0;
            frame_err_out <= 1'b0;
        end else begin
            valid_out <= done_q;
            if (done_q) begin
                data_out      <= shift_q;
                frame_err_out <= ~stop_q;
            end
        end
    end

`ifdef UART_RX_FRAMER_PARITY_EN
    // Even parity: data bits XOR parity bit must be zero.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            parity_err_out <= 1'b0;
        end else if (done_q) begin
            parity_err_out <= (^shift_q) ^ par_q;
        end
    end
`else
    assign parity_err_out = 1'b0;
`endif

    assign busy_out = (state_q != IDLE);

endmodule
